spi_tx_fifo_framed: RTL and testbench

- Parametrised single-clock transmit FIFO that buffers bytes from the host side and feeds the SPI MOSI shifter.
- Adds automatic chip-select framing: SPI_CS is asserted around bursts of BURST_LEN words, or around a shorter flushed frame.
- Adds level/almost-full status, a sticky overflow flag and a valid/ready handshake to the shifter.
- Sits between the host write interface and the SPI master shift register.

---
 rtl/spi_tx_fifo_framed.sv | 140 ++++++++++++++
 tb/tb_spi_tx_fifo_framed.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo_framed.sv
// Transmit FIFO feeding an SPI MOSI shifter, with automatic chip-select framing
// around BURST_LEN-word bursts (or shorter flushed frames) and level/overflow status.
module spi_tx_fifo_framed #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned ASIZE     = 4,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned AFULL_LVL = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DSIZE-1:0] wdata,
   input  logic             data_av,
   input  logic             flush,
   input  logic             tx_ready,
   output logic [DSIZE-1:0] data_to_mosi,
   output logic             tx_valid,
   output logic             spi_cs,
   output logic             frame_done,
   output logic             w_full,
   output logic             w_almost_full,
   output logic             w_overflow,
   output logic [ASIZE:0]   level
);

   localparam int unsigned DEPTH = 2 ** ASIZE;
   localparam int unsigned LW    = ASIZE + 1;
   localparam logic [ASIZE:0] L_DEPTH = LW'(DEPTH);
   localparam logic [ASIZE:0] L_BURST = LW'(BURST_LEN);
   localparam logic [ASIZE:0] L_AFULL = LW'(AFULL_LVL);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   logic [DSIZE-1:0] r_mem [DEPTH];
   logic [ASIZE-1:0] r_wptr;
   logic [ASIZE-1:0] r_rptr;
   logic [ASIZE:0]   r_level;
   logic [ASIZE:0]   r_remain;
   state_t           r_state;
   logic             r_flush_pend;
   logic             r_overflow;
   logic             r_tx_valid;
   logic             r_spi_cs;
   logic             r_frame_done;
   logic [DSIZE-1:0] r_data;

   logic             w_wr;
   logic             w_pop;
   logic             w_start;

   // Write acceptance, pop and frame-start decisions, all on registered level
   always_comb begin
      w_wr    = data_av && (r_level != L_DEPTH);
      w_pop   = (r_state == SETUP) ||
                ((r_state == XFER) && r_tx_valid && tx_ready && (r_remain != '0));
      w_start = (r_state == IDLE) &&
                ((r_level >= L_BURST) || (r_flush_pend && (r_level != '0)));
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= wdata;
   end

   // Pointers, level and sticky/pending flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_level      <= '0;
         r_overflow   <= 1'b0;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + ASIZE'(1);
         if (w_pop) r_rptr <= r_rptr + ASIZE'(1);
         if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
         if (data_av && (r_level == L_DEPTH)) r_overflow <= 1'b1;
         // A new flush request wins over a clear in the same cycle
         if (flush)
            r_flush_pend <= 1'b1;
         else if (w_start || ((r_state == IDLE) && (r_level == '0)))
            r_flush_pend <= 1'b0;
      end
   end

   // Framing FSM; frame length is frozen when leaving IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_remain     <= '0;
         r_data       <= '0;
         r_tx_valid   <= 1'b0;
         r_spi_cs     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_remain <= (r_level < L_BURST) ? r_level : L_BURST;
                  r_spi_cs <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_data     <= r_mem[r_rptr];
               r_remain   <= r_remain - LW'(1);
               r_tx_valid <= 1'b1;
               r_state    <= XFER;
            end
            XFER: begin
               if (r_tx_valid && tx_ready) begin
                  if (r_remain != '0) begin
                     r_data   <= r_mem[r_rptr];
                     r_remain <= r_remain - LW'(1);
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               r_spi_cs     <= 1'b0;
               r_frame_done <= 1'b1;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_to_mosi  = r_data;
   assign tx_valid      = r_tx_valid;
   assign spi_cs        = r_spi_cs;
   assign frame_done    = r_frame_done;
   assign w_full        = (r_level == L_DEPTH);
   assign w_almost_full = (r_level >= L_AFULL);
   assign w_overflow    = r_overflow;
   assign level         = r_level;

endmodule

// File: tb/tb_spi_tx_fifo_framed.sv
// Directed bench for spi_tx_fifo_framed: framing latency, flush, full/overflow,
// stalls, simultaneous write/pop and reset mid-frame, checked against a word scoreboard.
module tb_spi_tx_fifo_framed;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] wdata = '0;
   logic       data_av = 1'b0;
   logic       flush = 1'b0;
   logic       tx_ready = 1'b0;
   logic [7:0] data_to_mosi;
   logic       tx_valid;
   logic       spi_cs;
   logic       frame_done;
   logic       w_full;
   logic       w_almost_full;
   logic       w_overflow;
   logic [4:0] level;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] sb[$];

   spi_tx_fifo_framed #(
      .DSIZE(8), .ASIZE(4), .BURST_LEN(4), .AFULL_LVL(12)
   ) dut (
      .clk(clk), .rst(rst), .wdata(wdata), .data_av(data_av), .flush(flush),
      .tx_ready(tx_ready), .data_to_mosi(data_to_mosi), .tx_valid(tx_valid),
      .spi_cs(spi_cs), .frame_done(frame_done), .w_full(w_full),
      .w_almost_full(w_almost_full), .w_overflow(w_overflow), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit keep);
      data_av = 1'b1;
      wdata   = d;
      if (keep) sb.push_back(d);
      step();
      data_av = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int b = 0;
      while (!tx_valid && b < 50) begin step(); b++; end
      chk({tag, "_valid"}, 32'(tx_valid), 1);
   endtask

   // Follow one frame: every word offered while tx_ready=1 must match the scoreboard
   task automatic collect_frame(input string tag, input int exp_len);
      int b = 0;
      int n = 0;
      logic [7:0] e;
      while (!spi_cs && b < 50) begin step(); b++; end
      chk({tag, "_cs_rise"}, 32'(spi_cs), 1);
      b = 0;
      while (spi_cs && b < 60) begin
         if (tx_valid && tx_ready) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            chk({tag, "_data"}, 32'(data_to_mosi), 32'(e));
            n++;
         end
         step();
         b++;
      end
      chk({tag, "_cs_fall"}, 32'(spi_cs), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 1);
      chk({tag, "_len"}, 32'(n), 32'(exp_len));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit saw;

      // Reset state
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_cs", 32'(spi_cs), 0);
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_ovf", 32'(w_overflow), 0);
      chk("rst_full", 32'(w_full), 0);
      chk("rst_fd", 32'(frame_done), 0);

      // Burst of 4 with exact cycle latency
      tx_ready = 1'b1;
      wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
      repeat (3) step();
      chk("t1_level3", 32'(level), 3);
      chk("t1_no_cs", 32'(spi_cs), 0);
      wr(8'h44, 0);
      chk("t1_cs_n", 32'(spi_cs), 0);
      chk("t1_level4", 32'(level), 4);
      step();
      chk("t1_cs_n1", 32'(spi_cs), 1);
      chk("t1_valid_n1", 32'(tx_valid), 0);
      step();
      chk("t1_valid_n2", 32'(tx_valid), 1);
      chk("t1_d0", 32'(data_to_mosi), 32'h11);
      chk("t1_level_n2", 32'(level), 3);
      step();
      chk("t1_d1", 32'(data_to_mosi), 32'h22);
      step();
      chk("t1_d2", 32'(data_to_mosi), 32'h33);
      step();
      chk("t1_d3", 32'(data_to_mosi), 32'h44);
      chk("t1_valid_d3", 32'(tx_valid), 1);
      chk("t1_level0", 32'(level), 0);
      step();
      chk("t1_hold_valid", 32'(tx_valid), 0);
      chk("t1_hold_cs", 32'(spi_cs), 1);
      chk("t1_hold_fd", 32'(frame_done), 0);
      step();
      chk("t1_end_cs", 32'(spi_cs), 0);
      chk("t1_end_fd", 32'(frame_done), 1);
      step();
      chk("t1_fd_once", 32'(frame_done), 0);

      // Short flushed frame, then an empty flush and a stale-pending check
      wr(8'hA1, 1); wr(8'hA2, 1);
      repeat (4) step();
      chk("t2_no_cs", 32'(spi_cs), 0);
      pulse_flush();
      collect_frame("t2_flush", 2);
      pulse_flush();
      saw = 1'b0;
      repeat (10) begin step(); saw |= spi_cs; end
      chk("t2_empty_flush_cs", 32'(saw), 0);
      wr(8'h5A, 1);
      saw = 1'b0;
      repeat (8) begin step(); saw |= spi_cs; end
      chk("t2_no_stale_pend", 32'(saw), 0);
      chk("t2_level1", 32'(level), 1);
      pulse_flush();
      collect_frame("t2_one", 1);

      // Fill with shifter stalled: one word sits in the output register
      tx_ready = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         wr(8'(192 + k), k <= 17);
         if (k == 12) chk("t3_afull_11", 32'(w_almost_full), 0);
         if (k == 13) chk("t3_afull_12", 32'(w_almost_full), 1);
         if (k == 16) chk("t3_full_15", 32'(w_full), 0);
         if (k == 17) begin
            chk("t3_full_16", 32'(w_full), 1);
            chk("t3_ovf_before", 32'(w_overflow), 0);
         end
         if (k == 18) begin
            chk("t3_ovf", 32'(w_overflow), 1);
            chk("t3_level16", 32'(level), 16);
         end
      end
      tx_ready = 1'b1;
      repeat (4) collect_frame("t3_burst", 4);
      chk("t3_level_left", 32'(level), 1);
      chk("t3_ovf_sticky", 32'(w_overflow), 1);
      pulse_flush();
      collect_frame("t3_tail", 1);

      // Stall for 5 cycles mid-frame
      wr(8'hE1, 1); wr(8'hE2, 1); wr(8'hE3, 1); wr(8'hE4, 1);
      wait_valid("t4");
      chk("t4_d0", 32'(data_to_mosi), 32'(sb.pop_front()));
      step();
      chk("t4_d1", 32'(data_to_mosi), 32'hE2);
      tx_ready = 1'b0;
      repeat (5) begin
         step();
         chk("t4_stall_data", 32'(data_to_mosi), 32'hE2);
         chk("t4_stall_valid", 32'(tx_valid), 1);
         chk("t4_stall_cs", 32'(spi_cs), 1);
      end
      tx_ready = 1'b1;
      collect_frame("t4_resume", 3);

      // Simultaneous write and pop at level 8
      tx_ready = 1'b0;
      for (int k = 1; k <= 9; k++) wr(8'(128 + k), 1);
      chk("t5_level8", 32'(level), 8);
      chk("t5_valid", 32'(tx_valid), 1);
      chk("t5_d0", 32'(data_to_mosi), 32'(sb.pop_front()));
      tx_ready = 1'b1;
      wr(8'h9A, 1);
      chk("t5_level_same", 32'(level), 8);
      collect_frame("t5_first", 3);
      chk("t5_level6", 32'(level), 6);
      collect_frame("t5_second", 4);
      pulse_flush();
      collect_frame("t5_tail", 2);
      chk("t5_sb_empty", 32'(sb.size()), 0);

      // Reset while a frame is stalled in transfer
      tx_ready = 1'b0;
      for (int k = 0; k < 6; k++) wr(8'(16 + k), 0);
      step();
      chk("t6_pre_cs", 32'(spi_cs), 1);
      chk("t6_pre_valid", 32'(tx_valid), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_cs", 32'(spi_cs), 0);
      chk("t6_valid", 32'(tx_valid), 0);
      chk("t6_level", 32'(level), 0);
      chk("t6_ovf", 32'(w_overflow), 0);
      chk("t6_fd", 32'(frame_done), 0);
      step();
      chk("t6_fd_after", 32'(frame_done), 0);
      chk("t6_cs_after", 32'(spi_cs), 0);
      tx_ready = 1'b1;
      wr(8'h61, 1); wr(8'h62, 1); wr(8'h63, 1); wr(8'h64, 1);
      collect_frame("t6_recover", 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
